// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler and LSB-first sequencer for a shared
// bit-serial full adder. Latches the winning requester's operands, walks the
// adder through WIDTH bit cycles, and returns {cout, sum} with the requester
// id over a valid/ready response channel.
module serial_add_sched #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_en,
    output logic             fa_clr,
    input  logic             fa_s,
    input  logic             fa_co
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               last_grant_q;
    logic               id_q;
    logic [WIDTH-1:0]   opa_q, opb_q, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cout_q;

    logic               gnt_id;
    logic               accept;
    logic               last_bit;

    // Round-robin grant: a lone requester wins outright, a tie goes to the
    // requester that did not win last time. Gated by rst so every output
    // reads 0 while reset is held, even with a requester waiting.
    always_comb begin
        gnt_id = req1_valid;
        if (req0_valid && req1_valid) gnt_id = ~last_grant_q;
        accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        last_bit   = (cnt_q == LAST_BIT);
    end

    // Next-state logic and adder/response drive; the adder only sees
    // operand bits while RUN is active, and its carry is cleared on accept.
    always_comb begin
        state_d    = state_q;
        fa_en      = 1'b0;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_clr     = accept;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                fa_en = 1'b1;
                fa_a  = opa_q[cnt_q];
                fa_b  = opb_q[cnt_q];
                if (last_bit) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign resp_id   = id_q;
    assign resp_sum  = sum_q;
    assign resp_cout = cout_q;

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture on accept, then one sum bit per RUN cycle, LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            cout_q       <= 1'b0;
        end else begin
            if (accept) begin
                opa_q        <= gnt_id ? req1_a : req0_a;
                opb_q        <= gnt_id ? req1_b : req0_b;
                id_q         <= gnt_id;
                last_grant_q <= gnt_id;
                cnt_q        <= '0;
                sum_q        <= '0;
            end
            if (state_q == RUN) begin
                sum_q[cnt_q] <= fa_s;
                if (last_bit) cout_q <= fa_co;
                else          cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: models the external bit-serial adder (carry flop
// without reset, so only fa_clr can clear it) and checks results against
// plain a+b and the round-robin rule.
module tb_serial_add_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_cout, busy;
    logic [W-1:0] resp_sum;
    logic         fa_a, fa_b, fa_en, fa_clr, fa_s, fa_co;

    int checks = 0;
    int errors = 0;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy),
        .fa_a(fa_a), .fa_b(fa_b), .fa_en(fa_en), .fa_clr(fa_clr), .fa_s(fa_s), .fa_co(fa_co)
    );

    always #5 clk = ~clk;

    // External shared adder: starts with carry set so a missing clear shows up.
    logic carry = 1'b1;
    assign fa_s  = fa_a ^ fa_b ^ carry;
    assign fa_co = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);
    always @(posedge clk) begin
        if (fa_clr)     carry <= 1'b0;
        else if (fa_en) carry <= fa_co;
    end

    function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        return (W+1)'(a) + (W+1)'(b);
    endfunction

    // Wait (bounded) for a grant, report who won, then drop that requester.
    task automatic do_accept(output logic id, output logic clr, output bit ok);
        ok = 0; id = 0; clr = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                ok = 1; id = req1_ready; clr = fa_clr;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: no ready within 40 cycles");
        end
        @(negedge clk);
        if (ok) begin
            if (id) req1_valid = 0;
            else    req0_valid = 0;
        end
    endtask

    // Count edges/fa_en cycles until resp_valid, capture response, pop it.
    task automatic do_collect(output logic id, output logic [W-1:0] sum, output logic cout,
                              output int lat, output int en);
        lat = 0; en = 0;
        while (!resp_valid && lat < 40) begin
            en += int'(fa_en);
            @(negedge clk);
            lat++;
        end
        id = resp_id; sum = resp_sum; cout = resp_cout;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_sum, resp_cout, busy,
             fa_a, fa_b, fa_en, fa_clr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got r0=%b r1=%b rv=%b id=%b sum=%h co=%b busy=%b en=%b clr=%b, want all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, resp_sum, resp_cout, busy, fa_en, fa_clr);
        end
        rst = 0;
        @(negedge clk);
    endtask

    // Both requesters contend from reset: req0 first, then strict alternation.
    task automatic test_both();
        logic id, clr, co; logic [W-1:0] s; int lat, en; bit ok;
        logic [W-1:0] a0, b0, a1, b1; logic [W:0] exp;
        a0 = 4'h2; b0 = 4'h2; a1 = 4'h7; b1 = 4'h7;
        for (int i = 0; i < 6; i++) begin
            if (!req0_valid) begin req0_valid = 1; req0_a = a0; req0_b = b0; end
            if (!req1_valid && i < 5) begin req1_valid = 1; req1_a = a1; req1_b = b1; end
            do_accept(id, clr, ok);
            checks++;
            if (id !== 1'(i % 2)) begin
                errors++; $display("FAIL both_grant[%0d]: got id %b want %0d", i, id, i % 2);
            end
            exp = (i % 2) ? add_ref(a1, b1) : add_ref(a0, b0);
            do_collect(id, s, co, lat, en);
            checks++;
            if ({id, co, s} !== {1'(i % 2), exp}) begin
                errors++;
                $display("FAIL both_resp[%0d]: got id=%b co=%b sum=%h want id=%0d co=%b sum=%h",
                         i, id, co, s, i % 2, exp[W], exp[W-1:0]);
            end
            if (i % 2) begin a1 = W'($urandom); b1 = W'($urandom); end
            else       begin a0 = W'($urandom); b0 = W'($urandom); end
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_req0_only();
        logic id, clr, co; logic [W-1:0] s; int lat, en; bit ok;
        req0_valid = 1; req0_a = 4'h5; req0_b = 4'h3;
        do_accept(id, clr, ok);
        checks++;
        if (id !== 1'b0 || clr !== 1'b1) begin
            errors++; $display("FAIL r0_accept: got id=%b clr=%b want id=0 clr=1", id, clr);
        end
        checks++;
        if (req0_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL r0_ready_pulse: got ready=%b busy=%b want 0 1", req0_ready, busy);
        end
        do_collect(id, s, co, lat, en);
        checks++;
        if (lat !== W || en !== W) begin
            errors++; $display("FAIL r0_timing: got lat=%0d fa_en_cycles=%0d want %0d %0d", lat, en, W, W);
        end
        checks++;
        if ({id, co, s} !== {1'b0, 1'b0, 4'h8}) begin
            errors++; $display("FAIL r0_result: got id=%b co=%b sum=%h want 0 0 8", id, co, s);
        end
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL r0_idle: got rv=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_req1_only();
        logic id, clr, co; logic [W-1:0] s; int lat, en; bit ok;
        logic [W-1:0] b; logic [W:0] exp;
        for (int i = 0; i < 2; i++) begin
            b = (i == 0) ? 4'h1 : 4'hF;
            req1_valid = 1; req1_a = 4'hF; req1_b = b;
            do_accept(id, clr, ok);
            do_collect(id, s, co, lat, en);
            exp = (i == 0) ? 5'h10 : 5'h1E;
            checks++;
            if ({id, co, s} !== {1'b1, exp} || lat !== W) begin
                errors++;
                $display("FAIL r1_result[%0d]: got id=%b co=%b sum=%h lat=%0d want 1 %b %h %0d",
                         i, id, co, s, lat, exp[W], exp[W-1:0], W);
            end
        end
    endtask

    // Response back-pressure: everything holds, nothing else is granted.
    task automatic test_hold();
        logic id, clr, co; logic [W-1:0] s; int lat, en; bit ok;
        req0_valid = 1; req0_a = 4'h9; req0_b = 4'h8;
        do_accept(id, clr, ok);
        req1_valid = 1; req1_a = 4'h3; req1_b = 4'h4;
        for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({resp_valid, resp_id, resp_cout, resp_sum, req0_ready, req1_ready, fa_en} !==
                {1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d]: got rv=%b id=%b co=%b sum=%h r0=%b r1=%b en=%b want 1 0 1 1 0 0 0",
                         i, resp_valid, resp_id, resp_cout, resp_sum, req0_ready, req1_ready, fa_en);
            end
            @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: got rv=%b r1=%b want 0 1", resp_valid, req1_ready);
        end
        do_accept(id, clr, ok);
        do_collect(id, s, co, lat, en);
        checks++;
        if ({id, co, s} !== {1'b1, 1'b0, 4'h7}) begin
            errors++; $display("FAIL hold_next: got id=%b co=%b sum=%h want 1 0 7", id, co, s);
        end
    endtask

    // Reset on the 2nd RUN cycle with the adder carry set; next op must be clean.
    task automatic test_reset_mid();
        logic id, clr, co; logic [W-1:0] s; int lat, en; bit ok; bit seen;
        req0_valid = 1; req0_a = 4'hF; req0_b = 4'hF;
        do_accept(id, clr, ok);
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_sum, resp_cout, busy,
             fa_a, fa_b, fa_en, fa_clr} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got rv=%b sum=%h busy=%b en=%b a=%b b=%b want all 0",
                     resp_valid, resp_sum, busy, fa_en, fa_a, fa_b);
        end
        @(negedge clk);
        rst = 0;
        resp_ready = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        resp_ready = 0;
        checks++;
        if (seen) begin errors++; $display("FAIL midrun_noresp: got a response after reset, want none"); end
        req0_valid = 1; req0_a = 4'h1; req0_b = 4'h1;
        req1_valid = 1; req1_a = 4'h6; req1_b = 4'h3;
        do_accept(id, clr, ok);
        checks++;
        if (id !== 1'b0) begin errors++; $display("FAIL midrun_tie: got id %b want 0", id); end
        do_collect(id, s, co, lat, en);
        checks++;
        if ({id, co, s} !== {1'b0, 1'b0, 4'h2}) begin
            errors++; $display("FAIL midrun_carry: got id=%b co=%b sum=%h want 0 0 2", id, co, s);
        end
        do_accept(id, clr, ok);
        do_collect(id, s, co, lat, en);
        checks++;
        if ({id, co, s} !== {1'b1, 1'b0, 4'h9}) begin
            errors++; $display("FAIL midrun_second: got id=%b co=%b sum=%h want 1 0 9", id, co, s);
        end
    endtask

    typedef struct packed { logic id; logic [W:0] res; } exp_t;

    task automatic test_random();
        exp_t q[$]; exp_t e;
        logic last_win;
        logic exp_id;
        bit acc0, acc1;
        int ops, bad_rr, bad_res;
        ops = 0; bad_rr = 0; bad_res = 0; acc0 = 0; acc1 = 0;
        rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
        @(negedge clk);
        rst = 0;
        last_win = 1'b1;
        for (int cyc = 0; cyc < 20000 && (ops < 500 || q.size() != 0); cyc++) begin
            @(negedge clk);
            if (acc0) begin req0_valid = 0; acc0 = 0; end
            if (acc1) begin req1_valid = 0; acc1 = 0; end
            if (!req0_valid && ops < 500 && $urandom_range(0, 2) != 0) begin
                req0_valid = 1; req0_a = W'($urandom); req0_b = W'($urandom);
            end
            if (!req1_valid && ops < 500 && $urandom_range(0, 2) != 0) begin
                req1_valid = 1; req1_a = W'($urandom); req1_b = W'($urandom);
            end
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            if (req0_ready || req1_ready) begin
                exp_id = (req0_valid && req1_valid) ? ~last_win : req1_valid;
                checks++;
                if ((req0_ready && req1_ready) || req1_ready !== exp_id || q.size() != 0) begin
                    errors++;
                    if (bad_rr++ < 5)
                        $display("FAIL rand_grant: got r0=%b r1=%b pending=%0d want id %b with nothing pending",
                                 req0_ready, req1_ready, q.size(), exp_id);
                end
                e.id  = exp_id;
                e.res = exp_id ? add_ref(req1_a, req1_b) : add_ref(req0_a, req0_b);
                q.push_back(e);
                last_win = exp_id;
                if (exp_id) acc1 = 1; else acc0 = 1;
                ops++;
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    if (bad_res++ < 5) $display("FAIL rand_spurious: got a response with none expected");
                end else begin
                    e = q.pop_front();
                    if ({resp_id, resp_cout, resp_sum} !== {e.id, e.res}) begin
                        errors++;
                        if (bad_res++ < 5)
                            $display("FAIL rand_result: got id=%b co=%b sum=%h want id=%b co=%b sum=%h",
                                     resp_id, resp_cout, resp_sum, e.id, e.res[W], e.res[W-1:0]);
                    end
                end
            end
        end
        req0_valid = 0; req1_valid = 0; resp_ready = 0;
        checks++;
        if (q.size() != 0 || ops < 500) begin
            errors++; $display("FAIL rand_drain: got %0d ops, %0d unanswered, want >=500 and 0", ops, q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_both();
        test_req0_only();
        test_req1_only();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
